// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC exponential arbiter:
//   - Q16.16 constants (convergence limit, exp(0), default core latency)
//   - tag_t: the per-operation tag {tv, id, clip} that travels alongside the core
//   - q16_clamp: saturates an operand to +/-lim and reports whether it changed
// ----------------------------------------------------------------------------
package cordic_pkg;

    // Default pipeline depth of the cordic_exp core.
    localparam int DEF_LATENCY = 18;

    // Convergence limit, 1.13 in Q16.16.
    localparam logic signed [31:0] Q_ZLIM = 32'sd74055;

    // exp(0) = 1.0 in Q16.16.
    localparam logic signed [31:0] Q_ONE = 32'sd65536;

    // Tag id field is sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                tv;    // an operation occupies this slot
        logic [TAG_ID_W-1:0] id;    // owning requester
        logic                clip;  // operand was saturated
    } tag_t;

    localparam tag_t TAG_ZERO = '{tv: 1'b0, id: {TAG_ID_W{1'b0}}, clip: 1'b0};

    // Returns {clip, value}: value is d saturated to [-lim, +lim] (32-bit signed
    // compare), clip is set only when the operand had to be modified.
    function automatic logic [32:0] q16_clamp(input logic signed [31:0] d,
                                              input logic signed [31:0] lim);
        logic [32:0] res;
        if (d > lim) begin
            res = {1'b1, lim};
        end else if (d < -lim) begin
            res = {1'b1, -lim};
        end else begin
            res = {1'b0, d};
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The grant is combinational: the first requester with
// i_req set, scanning upward from the priority pointer modulo N. After a grant
// to index i the pointer moves to (i+1) mod N; with no grant it holds.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset (pointer -> 0)
//   i_req[N]      request vector
//   o_grant[N]    one-hot grant (all zero when nothing is requested)
//   o_grant_idx   binary index of the granted requester
//   o_grant_any   a grant is being given this cycle
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    i_req,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_grant_idx,
    output logic            o_grant_any
);

    logic [ID_W-1:0] r_ptr;
    logic            w_found;
    logic [ID_W-1:0] w_idx;

    // Scan from the pointer upward and pick the first active requester
    always_comb begin
        w_found = 1'b0;
        w_idx   = {ID_W{1'b0}};
        for (int k = 0; k < N; k++) begin
            int              scan;
            logic [ID_W-1:0] scan_idx;
            scan     = (int'(r_ptr) + k) % N;
            scan_idx = ID_W'(scan);
            if (!w_found && i_req[scan_idx]) begin
                w_found = 1'b1;
                w_idx   = scan_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Expand the winning index to a one-hot grant
    always_comb begin
        o_grant = {N{1'b0}};
        if (w_found) begin
            o_grant[w_idx] = 1'b1;
        end else begin
            o_grant = {N{1'b0}};
        end
    end

    assign o_grant_idx = w_idx;
    assign o_grant_any = w_found;

    // Priority pointer: one past the last winner, wrapping at N-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= {ID_W{1'b0}};
        end else if (w_found) begin
            r_ptr <= (w_idx == ID_W'(N - 1)) ? {ID_W{1'b0}} : (w_idx + 1'b1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/cordic_exp_arb.sv
// ----------------------------------------------------------------------------
// cordic_exp_arb
// Shares one fully pipelined cordic_exp core between N_REQ requesters.
// One request is accepted per cycle (round robin), its operand is clamped to
// +/-ZLIM and issued to the core, and a tag {tv, id, clip} follows it through a
// LATENCY-deep shift register so each core result can be returned tagged with
// its owner. A disagreement between the core's output valid and the tag valid
// sets the sticky err_align flag.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid[N]      per-requester request valid
//   req_data[N*32]    per-requester Q16.16 operand, slot i at [32i+31:32i]
//   req_ready[N]      one-hot grant (combinational)
//   core_idata        clamped operand to the core
//   core_valid        operand valid to the core
//   core_exp          core result
//   core_post_valid   core result valid
//   rsp_valid         response pulse, one per result
//   rsp_id            owner of the response
//   rsp_data          exp result, Q16.16
//   rsp_clip          the operand behind this result was clamped
//   err_align         sticky core/tag valid mismatch
// ----------------------------------------------------------------------------
module cordic_exp_arb
    import cordic_pkg::*;
#(
    parameter int                N_REQ   = 4,
    parameter int                ID_W    = 2,
    parameter int                LATENCY = DEF_LATENCY,
    parameter logic signed [31:0] ZLIM   = Q_ZLIM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           core_idata,
    output logic                  core_valid,
    input  logic [31:0]           core_exp,
    input  logic                  core_post_valid,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_clip,
    output logic                  err_align
);

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_gidx;
    logic             w_gany;
    logic [31:0]      w_sel_data;
    logic [32:0]      w_clamped;

    logic             r_core_valid;
    logic [31:0]      r_core_idata;
    logic [ID_W-1:0]  r_iss_id;
    logic             r_iss_clip;

    tag_t             w_tag_in;
    tag_t             w_last_tag;
    logic             w_unused_tag_bits;

    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [31:0]      r_rsp_data;
    logic             r_rsp_clip;
    logic             r_err_align;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req_valid),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_grant_any (w_gany)
    );

    assign req_ready  = w_grant;
    assign w_sel_data = req_data[32*int'(w_gidx) +: 32];
    assign w_clamped  = q16_clamp(w_sel_data, ZLIM);

    // Issue register: capture the granted, clamped operand and its owner.
    // The operand holds its last value on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_valid <= 1'b0;
            r_core_idata <= 32'd0;
            r_iss_id     <= {ID_W{1'b0}};
            r_iss_clip   <= 1'b0;
        end else if (w_gany) begin
            r_core_valid <= 1'b1;
            r_core_idata <= w_clamped[31:0];
            r_iss_id     <= w_gidx;
            r_iss_clip   <= w_clamped[32];
        end else begin
            r_core_valid <= 1'b0;
            r_core_idata <= r_core_idata;
            r_iss_id     <= r_iss_id;
            r_iss_clip   <= r_iss_clip;
        end
    end

    assign core_valid = r_core_valid;
    assign core_idata = r_core_idata;

    assign w_tag_in = '{tv: r_core_valid, id: TAG_ID_W'(r_iss_id), clip: r_iss_clip};

    // Tag pipe: stage g lines up with core pipeline stage g, so the last stage
    // is aligned with core_post_valid.
    generate
        for (genvar g = 0; g < LATENCY; g++) begin : g_tag
            tag_t r_stage;
            if (g == 0) begin : g_head
                // First stage captures the issue register
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_stage <= TAG_ZERO;
                    end else begin
                        r_stage <= w_tag_in;
                    end
                end
            end else begin : g_body
                // Later stages shift unconditionally every cycle
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_stage <= TAG_ZERO;
                    end else begin
                        r_stage <= g_tag[g-1].r_stage;
                    end
                end
            end
        end
    endgenerate

    assign w_last_tag = g_tag[LATENCY-1].r_stage;

    // The id field is wider than ID_W for small requester counts.
    assign w_unused_tag_bits = ^w_last_tag.id;

    // Response register and sticky alignment check. The response valid always
    // follows the core, even when the tag disagrees.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= {ID_W{1'b0}};
            r_rsp_data  <= 32'd0;
            r_rsp_clip  <= 1'b0;
            r_err_align <= 1'b0;
        end else begin
            r_rsp_valid <= core_post_valid;
            r_rsp_data  <= core_exp;
            r_rsp_id    <= w_last_tag.id[ID_W-1:0];
            r_rsp_clip  <= w_last_tag.clip;
            if (core_post_valid != w_last_tag.tv) begin
                r_err_align <= 1'b1;
            end else begin
                r_err_align <= r_err_align;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_clip  = r_rsp_clip;
    assign err_align = r_err_align;

endmodule

// File: tb/tb_cordic_exp_arb.sv
// ----------------------------------------------------------------------------
// tb_cordic_exp_arb
// Drives cordic_exp_arb with directed and random requests. A behavioural
// stand-in for the cordic_exp core (real-valued exp, fixed latency) sits on the
// core ports. A reference model (round-robin scan + clamp + expected-response
// queue) predicts grants and tagged responses, including their arrival cycle.
// ----------------------------------------------------------------------------
module tb_cordic_exp_arb;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 18;
    localparam int ZL   = 74055;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*32-1:0] req_data  = '0;
    logic [N-1:0]    req_ready;
    logic [31:0]     core_idata;
    logic            core_valid;
    logic [31:0]     core_exp;
    logic            core_post_valid;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_clip;
    logic            err_align;

    logic            spur = 1'b0;

    cordic_exp_arb dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .core_idata      (core_idata),
        .core_valid      (core_valid),
        .core_exp        (core_exp),
        .core_post_valid (core_post_valid),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .rsp_clip        (rsp_clip),
        .err_align       (err_align)
    );

    always #5 clk = ~clk;

    function automatic int ref_exp(input int z);
        real r;
        r = $exp($itor(z) / 65536.0) * 65536.0;
        return $rtoi(r + 0.5);
    endfunction

    // Core stand-in: exp computed at the input, delayed LAT cycles.
    logic [31:0] cp_d [LAT];
    logic        cp_v [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                cp_d[i] <= '0;
                cp_v[i] <= 1'b0;
            end
        end else begin
            cp_v[0] <= core_valid;
            cp_d[0] <= 32'(ref_exp($signed(core_idata)));
            for (int i = 1; i < LAT; i++) begin
                cp_v[i] <= cp_v[i-1];
                cp_d[i] <= cp_d[i-1];
            end
        end
    end
    assign core_exp        = cp_d[LAT-1];
    assign core_post_valid = cp_v[LAT-1] | spur;

    typedef struct {
        int id;
        int data;
        int clip;
        int due;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   mptr = 0;
    bit   exp_err = 1'b0;
    bit   spur_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: predict the grant, check it, advance, then score outputs.
    task automatic tick();
        int           gi;
        logic [N-1:0] eg;
        exp_t         e;
        int           d;
        int           z;
        #1;
        gi = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mptr + k) % N;
            if (gi < 0 && req_valid[idx]) gi = idx;
        end
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(eg));
        if (gi >= 0) begin
            d = $signed(req_data[32*gi +: 32]);
            z = (d > ZL) ? ZL : ((d < -ZL) ? -ZL : d);
            e.id   = gi;
            e.data = ref_exp(z);
            e.clip = (z != d) ? 1 : 0;
            e.due  = cyc + 2 + LAT;
            q.push_back(e);
            mptr = (gi + 1) % N;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                if (!spur_ok) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_id",    32'(rsp_id),   32'(e.id));
                chk("rsp_data",  rsp_data,      32'(e.data));
                chk("rsp_clip",  32'(rsp_clip), 32'(e.clip));
                chk("rsp_cycle", 32'(cyc),      32'(e.due));
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("rsp_missing", 32'(rsp_valid), 32'd1);
            void'(q.pop_front());
        end
        chk("err_align", 32'(err_align), 32'(exp_err));
    endtask

    int clamp_in  [6] = '{131072, -131072, 74055, 74056, -74055, -74056};
    int clamp_out [6] = '{74055, -74055, 74055, 74055, -74055, -74055};

    initial begin
        // Reset state
        #1;
        chk("rst_core_valid", 32'(core_valid), 32'd0);
        chk("rst_core_idata", core_idata,      32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("rst_rsp_data",   rsp_data,        32'd0);
        chk("rst_rsp_clip",   32'(rsp_clip),   32'd0);
        chk("rst_err_align",  32'(err_align),  32'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst_ready_prio0", 32'(req_ready), 32'd1);
        req_valid = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Single request from requester 2 with operand 0
        req_valid = 4'b0100;
        req_data  = '0;
        tick();
        req_valid = '0;
        repeat (LAT + 4) tick();

        // All requesters continuously valid, data i*16384
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'(i * 16384);
        req_valid = 4'b1111;
        repeat (12) tick();
        req_valid = '0;
        repeat (LAT + 4) tick();

        // Clamp boundaries on requester 0
        req_valid = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            req_data[31:0] = 32'(clamp_in[i]);
            tick();
            chk("core_idata_clamp", core_idata, 32'(clamp_out[i]));
        end
        req_valid = '0;
        repeat (LAT + 4) tick();

        // Sparse random traffic on requesters 0, 1 and 3
        for (int n = 0; n < 1000; n++) begin
            req_valid[0] = ($urandom_range(0, 99) < 30);
            req_valid[1] = ($urandom_range(0, 99) < 30);
            req_valid[2] = 1'b0;
            req_valid[3] = ($urandom_range(0, 99) < 30);
            for (int i = 0; i < N; i++)
                req_data[32*i +: 32] = 32'(int'($urandom_range(0, 262144)) - 131072);
            tick();
        end
        req_valid = '0;
        repeat (LAT + 4) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);

        // Spurious core valid with nothing in flight
        spur    = 1'b1;
        spur_ok = 1'b1;
        exp_err = 1'b1;
        tick();
        spur    = 1'b0;
        tick();
        spur_ok = 1'b0;
        repeat (5) tick();

        // Reset while about ten operations are in flight
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'(i * 4096);
        req_valid = 4'b1111;
        repeat (10) tick();
        rst       = 1'b1;
        req_valid = '0;
        #1;
        chk("mid_rst_core_valid", 32'(core_valid), 32'd0);
        chk("mid_rst_core_idata", core_idata,      32'd0);
        chk("mid_rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("mid_rst_rsp_id",     32'(rsp_id),     32'd0);
        chk("mid_rst_rsp_data",   rsp_data,        32'd0);
        chk("mid_rst_rsp_clip",   32'(rsp_clip),   32'd0);
        chk("mid_rst_err_align",  32'(err_align),  32'd0);
        chk("mid_rst_ready",      32'(req_ready),  32'd0);
        q.delete();
        mptr    = 0;
        exp_err = 1'b0;
        tick();
        rst = 1'b0;
        repeat (LAT + 4) tick();

        // Pointer restarts at 0: requesters 1 and 3 together -> 1 first
        req_valid = 4'b1010;
        tick();
        req_valid = '0;
        repeat (LAT + 4) tick();
        chk("final_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
